xsip_telemetry_scan: RTL and testbench
======================================

# xsip_telemetry_scan

Parametrised IC-level telemetry aggregator for the XSIP telemetry path. It snapshots NUM_CH sensor channels (temperature, PMIC rails, margins) on a programmable sample period and scans them sequentially, one channel per cycle. Each frame publishes sum, min, max, argmax and valid count over a valid/ready handshake. It replaces fixed-count, every-cycle combinational reduction with a bounded-area serial scan, per-channel valid masking, frame sequencing and overrun detection.

## Interface
- NUM_CH, 16, channel count, ≥2
- DATA_W, 16, per-channel sample width
- PERIOD_W, 16, width of sample_period
- SEQ_W, 16, frame sequence counter width

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run; low aborts to IDLE
- sample_period  in  PERIOD_W  idle cycles between frames; 0 treated as 1
- ch_data  in  NUM_CH*DATA_W  flat channel samples, channel i at [i*DATA_W +: DATA_W]
- ch_valid  in  NUM_CH  per-channel valid mask
- alarm_thresh  in  DATA_W  high-alarm threshold
- out_ready  in  1  consumer accepts frame
- clr_overrun  in  1  clears overrun
- out_valid  out  1  frame available
- out_sum  out  DATA_W+$clog2(NUM_CH)  sum of valid channels
- out_min, out_max  out  DATA_W  min/max of valid channels
- out_max_idx  out  $clog2(NUM_CH)  index of out_max
- out_cnt  out  $clog2(NUM_CH)+1  number of valid channels
- out_seq  out  SEQ_W  frame sequence number
- alarm_mask  out  NUM_CH  channels above threshold
- alarm  out  1  |alarm_mask
- overrun  out  1  sticky: unread frame overwritten
- busy  out  1  state is SCAN

## Operation
- FSM: IDLE, WAIT, SCAN.
- IDLE: enable=1 → WAIT; load period counter with max(sample_period,1).
- WAIT: count down; on last WAIT cycle, snapshot ch_data and ch_valid into internal regs, clear accumulators (sum=0, min=all-ones, max=0, idx=0, cnt=0, mask=0) → SCAN, scan index 0.
- SCAN: per cycle process snapshot channel k. If valid: sum+=data; cnt+=1; data<min → min=data; data>max (strict) → max=data, idx=k. Ties keep lowest index. Invalid channels are ignored entirely.
- After k=NUM_CH-1: publish. Output regs ← accumulators, out_seq+=1 (wraps mod 2^SEQ_W), out_valid=1. Return to WAIT and reload sample_period.
- No valid channels: publish sum=0, min=all-ones, max=0, idx=0, cnt=0.
- Handshake: frame consumed on clk edge where out_valid&&out_ready; out_valid drops next cycle unless a publish occurs on the same edge.
- Publish while out_valid=1 and out_ready=0: overwrite, set overrun. Publish on a consume edge: no overrun.
- overrun clears on clr_overrun; simultaneous set and clear → set wins.
- enable=0 in any state → IDLE next edge; partial frame discarded; output regs, out_valid and out_seq are retained.
- Output regs are stable while out_valid=1 and no publish occurs.

## Timing
- Reset value of all outputs is 0, except out_min = all-ones. State IDLE.
- Frame period: P + NUM_CH cycles, P = max(sample_period,1).
- Latency: enable high at edge e → snapshot at e+P; out_valid high after edge e+P+NUM_CH.
- Snapshot latches data at the last WAIT edge; later input changes do not affect that frame.
- busy is a registered state decode.

## Configuration
- XSIP_TELEM_ALARM_EN defined: during SCAN, a valid channel with data > alarm_thresh (strict) sets alarm_mask[k]. Mask and alarm publish together with the frame. alarm_thresh is sampled at snapshot.
- Undefined: alarm_mask and alarm are tied 0, alarm_thresh is ignored, and no alarm logic is synthesised. Ports remain present.

## Test plan
- NUM_CH=4, period=3, data {10,40,40,5}, all valid, out_ready=1 → out_valid after 7 cycles from enable; sum=95, min=5, max=40, idx=1, cnt=4, seq=1.
- Mask ch_valid=4'b0000 → sum=0, min=16'hFFFF, max=0, cnt=0. Mask 4'b0101 with data {7,99,3,99} → sum=10, max=7, idx=0, cnt=2.
- out_ready=0 for two frames → second publish sets overrun and seq=2. clr_overrun clears it. Publish coincident with a ready pulse → overrun stays 0.
- Deassert enable mid-SCAN (k=2) → IDLE next cycle; out_* unchanged, no publish. Re-enable → full P+NUM_CH latency.
- sample_period=0 → frame period 1+NUM_CH. Run 2^SEQ_W+1 frames → out_seq wraps to 1.
- With XSIP_TELEM_ALARM_EN, thresh=39, data {10,40,40,5} → alarm_mask=4'b0110, alarm=1. Without the macro → both 0.

Source files
------------

// File: rtl/xsip_telemetry_scan_if.sv
// Signal bundle for xsip_telemetry_scan: run control, channel samples and the frame output handshake.
// Directions (_i/_o) are named from the telemetry block's side; master = telemetry block, slave = host.
interface xsip_telemetry_scan_if #(
  parameter int NUM_CH   = 16,
  parameter int DATA_W   = 16,
  parameter int PERIOD_W = 16,
  parameter int SEQ_W    = 16
);
  localparam int IDX_W = $clog2(NUM_CH);

  logic                       enable_i;
  logic [PERIOD_W-1:0]        sample_period_i;
  logic [NUM_CH*DATA_W-1:0]   ch_data_i;
  logic [NUM_CH-1:0]          ch_valid_i;
  logic [DATA_W-1:0]          alarm_thresh_i;
  logic                       out_ready_i;
  logic                       clr_overrun_i;
  logic                       out_valid_o;
  logic [DATA_W+IDX_W-1:0]    out_sum_o;
  logic [DATA_W-1:0]          out_min_o;
  logic [DATA_W-1:0]          out_max_o;
  logic [IDX_W-1:0]           out_max_idx_o;
  logic [IDX_W:0]             out_cnt_o;
  logic [SEQ_W-1:0]           out_seq_o;
  logic [NUM_CH-1:0]          alarm_mask_o;
  logic                       alarm_o;
  logic                       overrun_o;
  logic                       busy_o;

  modport master (
    input  enable_i, sample_period_i, ch_data_i, ch_valid_i, alarm_thresh_i,
           out_ready_i, clr_overrun_i,
    output out_valid_o, out_sum_o, out_min_o, out_max_o, out_max_idx_o, out_cnt_o,
           out_seq_o, alarm_mask_o, alarm_o, overrun_o, busy_o
  );

  modport slave (
    output enable_i, sample_period_i, ch_data_i, ch_valid_i, alarm_thresh_i,
           out_ready_i, clr_overrun_i,
    input  out_valid_o, out_sum_o, out_min_o, out_max_o, out_max_idx_o, out_cnt_o,
           out_seq_o, alarm_mask_o, alarm_o, overrun_o, busy_o
  );
endinterface

// File: rtl/xsip_telemetry_scan.sv
// Serial telemetry aggregator: snapshots NUM_CH channels each sample period and scans one per cycle
// into sum/min/max/argmax/count frames. Optional high-alarm mask enabled by XSIP_TELEM_ALARM_EN.
module xsip_telemetry_scan #(
  parameter int NUM_CH   = 16,
  parameter int DATA_W   = 16,
  parameter int PERIOD_W = 16,
  parameter int SEQ_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  xsip_telemetry_scan_if.master bus
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = IDX_W + 1;
  localparam int SUM_W = DATA_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_SCAN = 2'b10
  } state_e;

  state_e                         state_q, state_d;
  logic [PERIOD_W-1:0]            per_cnt_q, per_cnt_d, per_load_s;
  logic [IDX_W-1:0]               scan_k_q, scan_k_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  snap_data_q, snap_data_d;
  logic [NUM_CH-1:0]              snap_valid_q, snap_valid_d;
  logic [SUM_W-1:0]               acc_sum_q, acc_sum_d;
  logic [DATA_W-1:0]              acc_min_q, acc_min_d, acc_max_q, acc_max_d;
  logic [IDX_W-1:0]               acc_idx_q, acc_idx_d;
  logic [CNT_W-1:0]               acc_cnt_q, acc_cnt_d;
  logic                           out_valid_q, out_valid_d;
  logic [SUM_W-1:0]               out_sum_q, out_sum_d;
  logic [DATA_W-1:0]              out_min_q, out_min_d, out_max_q, out_max_d;
  logic [IDX_W-1:0]               out_idx_q, out_idx_d;
  logic [CNT_W-1:0]               out_cnt_q, out_cnt_d;
  logic [SEQ_W-1:0]               out_seq_q, out_seq_d;
  logic                           overrun_q, overrun_d;
  logic                           busy_q, busy_d;
  logic [DATA_W-1:0]              cur_data_s;
  logic                           cur_valid_s;
  logic                           snap_s, scan_s, publish_s;

  // A zero period behaves as a single idle cycle.
  assign per_load_s = (bus.sample_period_i == '0) ? PERIOD_W'(1'b1) : bus.sample_period_i;
  assign cur_data_s  = snap_data_q[scan_k_q];
  assign cur_valid_s = snap_valid_q[scan_k_q];

  // Next state, snapshot capture and per-channel accumulation.
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    scan_k_d     = scan_k_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    acc_sum_d    = acc_sum_q;
    acc_min_d    = acc_min_q;
    acc_max_d    = acc_max_q;
    acc_idx_d    = acc_idx_q;
    acc_cnt_d    = acc_cnt_q;
    snap_s       = 1'b0;
    scan_s       = 1'b0;
    publish_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable_i) begin
          state_d   = ST_WAIT;
          per_cnt_d = per_load_s;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bus.enable_i) begin
          state_d = ST_IDLE;
        end else if (per_cnt_q <= PERIOD_W'(1'b1)) begin
          state_d      = ST_SCAN;
          snap_s       = 1'b1;
          scan_k_d     = '0;
          snap_data_d  = bus.ch_data_i;
          snap_valid_d = bus.ch_valid_i;
          acc_sum_d    = '0;
          acc_min_d    = '1;
          acc_max_d    = '0;
          acc_idx_d    = '0;
          acc_cnt_d    = '0;
        end else begin
          per_cnt_d = per_cnt_q - PERIOD_W'(1'b1);
        end
      end
      ST_SCAN: begin
        if (!bus.enable_i) begin
          state_d = ST_IDLE;
        end else begin
          scan_s = 1'b1;
          if (cur_valid_s) begin
            acc_sum_d = acc_sum_q + SUM_W'(cur_data_s);
            acc_cnt_d = acc_cnt_q + CNT_W'(1'b1);
            if (cur_data_s < acc_min_q) begin
              acc_min_d = cur_data_s;
            end else begin
              acc_min_d = acc_min_q;
            end
            // Strict compare keeps the lowest index on ties.
            if (cur_data_s > acc_max_q) begin
              acc_max_d = cur_data_s;
              acc_idx_d = scan_k_q;
            end else begin
              acc_max_d = acc_max_q;
              acc_idx_d = acc_idx_q;
            end
          end else begin
            acc_sum_d = acc_sum_q;
          end
          if (scan_k_q == LAST_IDX) begin
            publish_s = 1'b1;
            state_d   = ST_WAIT;
            per_cnt_d = per_load_s;
            scan_k_d  = '0;
          end else begin
            scan_k_d  = scan_k_q + IDX_W'(1'b1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output frame publish, consumer handshake and sticky overrun.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_min_d   = out_min_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_cnt_d   = out_cnt_q;
    out_seq_d   = out_seq_q;
    overrun_d   = overrun_q;
    if (publish_s) begin
      out_valid_d = 1'b1;
      out_sum_d   = acc_sum_d;
      out_min_d   = acc_min_d;
      out_max_d   = acc_max_d;
      out_idx_d   = acc_idx_d;
      out_cnt_d   = acc_cnt_d;
      out_seq_d   = out_seq_q + SEQ_W'(1'b1);
    end else if (out_valid_q && bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (publish_s && out_valid_q && !bus.out_ready_i) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    busy_d = (state_d == ST_SCAN);
  end

  // State, scan datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      per_cnt_q    <= '0;
      scan_k_q     <= '0;
      snap_data_q  <= '0;
      snap_valid_q <= '0;
      acc_sum_q    <= '0;
      acc_min_q    <= '1;
      acc_max_q    <= '0;
      acc_idx_q    <= '0;
      acc_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_min_q    <= '1;
      out_max_q    <= '0;
      out_idx_q    <= '0;
      out_cnt_q    <= '0;
      out_seq_q    <= '0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      scan_k_q     <= scan_k_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      acc_sum_q    <= acc_sum_d;
      acc_min_q    <= acc_min_d;
      acc_max_q    <= acc_max_d;
      acc_idx_q    <= acc_idx_d;
      acc_cnt_q    <= acc_cnt_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_min_q    <= out_min_d;
      out_max_q    <= out_max_d;
      out_idx_q    <= out_idx_d;
      out_cnt_q    <= out_cnt_d;
      out_seq_q    <= out_seq_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_sum_o     = out_sum_q;
  assign bus.out_min_o     = out_min_q;
  assign bus.out_max_o     = out_max_q;
  assign bus.out_max_idx_o = out_idx_q;
  assign bus.out_cnt_o     = out_cnt_q;
  assign bus.out_seq_o     = out_seq_q;
  assign bus.overrun_o     = overrun_q;
  assign bus.busy_o        = busy_q;

`ifdef XSIP_TELEM_ALARM_EN
  logic [DATA_W-1:0] thresh_q, thresh_d;
  logic [NUM_CH-1:0] mask_q, mask_d, alarm_mask_q, alarm_mask_d;
  logic              alarm_q, alarm_d;

  // Threshold capture at snapshot, per-channel alarm accumulation, publish with the frame.
  always_comb begin
    thresh_d     = thresh_q;
    mask_d       = mask_q;
    alarm_mask_d = alarm_mask_q;
    alarm_d      = alarm_q;
    if (snap_s) begin
      thresh_d = bus.alarm_thresh_i;
      mask_d   = '0;
    end else if (scan_s && cur_valid_s && (cur_data_s > thresh_q)) begin
      mask_d[scan_k_q] = 1'b1;
    end else begin
      mask_d = mask_q;
    end
    if (publish_s) begin
      alarm_mask_d = mask_d;
      alarm_d      = |mask_d;
    end else begin
      alarm_mask_d = alarm_mask_q;
      alarm_d      = alarm_q;
    end
  end

  // Alarm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh_q     <= '0;
      mask_q       <= '0;
      alarm_mask_q <= '0;
      alarm_q      <= 1'b0;
    end else begin
      thresh_q     <= thresh_d;
      mask_q       <= mask_d;
      alarm_mask_q <= alarm_mask_d;
      alarm_q      <= alarm_d;
    end
  end

  assign bus.alarm_mask_o = alarm_mask_q;
  assign bus.alarm_o      = alarm_q;
`else
  logic unused_alarm_s;
  assign unused_alarm_s   = ^{bus.alarm_thresh_i, snap_s, scan_s};
  assign bus.alarm_mask_o = '0;
  assign bus.alarm_o      = 1'b0;
`endif

endmodule

// File: tb/tb_xsip_telemetry_scan.sv
// Self-checking bench for xsip_telemetry_scan: directed test-plan scenarios plus randomized traffic,
// all outputs compared every cycle against a frame-level reference model.
module tb_xsip_telemetry_scan;
  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 16;
  localparam int PERIOD_W = 8;
  localparam int SEQ_W    = 4;
  localparam int IDX_W    = 2;
  localparam int SUM_W    = DATA_W + IDX_W;
`ifdef XSIP_TELEM_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xsip_telemetry_scan_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .SEQ_W(SEQ_W)) bus ();

  xsip_telemetry_scan #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .SEQ_W(SEQ_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: run flag, countdowns to snapshot/publish, captured frame and expected outputs.
  bit                m_run;
  int                m_wait, m_scan;
  bit                m_pub;
  logic [DATA_W-1:0] s_data [NUM_CH];
  logic [NUM_CH-1:0] s_valid;
  logic [DATA_W-1:0] s_thresh;
  logic              e_valid, e_ovr, e_busy, e_alarm;
  logic [SUM_W-1:0]  e_sum;
  logic [DATA_W-1:0] e_min, e_max;
  logic [IDX_W-1:0]  e_idx;
  logic [IDX_W:0]    e_cnt;
  logic [SEQ_W-1:0]  e_seq;
  logic [NUM_CH-1:0] e_mask;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_wait = 0; m_scan = -1; m_pub = 1'b0;
    e_valid = 1'b0; e_ovr = 1'b0; e_busy = 1'b0; e_alarm = 1'b0;
    e_sum = '0; e_min = '1; e_max = '0; e_idx = '0; e_cnt = '0; e_seq = '0; e_mask = '0;
  endtask

  function automatic int period_of(input logic [PERIOD_W-1:0] sp);
    return (sp == 0) ? 1 : int'(sp);
  endfunction

  task automatic model_publish();
    int sum, c, found;
    logic [DATA_W-1:0] mn, mx;
    sum = 0; c = 0; mn = '1; mx = '0; e_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_valid[i]) begin
        sum += int'(s_data[i]);
        c++;
        if (s_data[i] < mn) mn = s_data[i];
        if (s_data[i] > mx) mx = s_data[i];
        if (ALARM_ON && s_data[i] > s_thresh) e_mask[i] = 1'b1;
      end
    end
    e_idx = '0;
    found = 0;
    if (mx != 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (found == 0 && s_valid[i] && s_data[i] == mx) begin
          e_idx = IDX_W'(i);
          found = 1;
        end
      end
    end
    e_sum = SUM_W'(sum); e_cnt = 3'(c); e_min = mn; e_max = mx; e_alarm = |e_mask;
    e_seq = e_seq + 1'b1;
  endtask

  task automatic model_edge();
    logic old_v;
    m_pub = 1'b0;
    if (!m_run) begin
      if (bus.enable_i) begin m_run = 1'b1; m_wait = period_of(bus.sample_period_i); m_scan = -1; end
    end else if (!bus.enable_i) begin
      m_run = 1'b0; m_scan = -1;
    end else if (m_scan < 0) begin
      m_wait--;
      if (m_wait == 0) begin
        for (int i = 0; i < NUM_CH; i++) s_data[i] = bus.ch_data_i[i*DATA_W +: DATA_W];
        s_valid = bus.ch_valid_i; s_thresh = bus.alarm_thresh_i; m_scan = NUM_CH;
      end
    end else begin
      m_scan--;
      if (m_scan == 0) begin m_pub = 1'b1; m_scan = -1; m_wait = period_of(bus.sample_period_i); end
    end
    old_v = e_valid;
    if (m_pub) begin model_publish(); e_valid = 1'b1; end
    else if (old_v && bus.out_ready_i) e_valid = 1'b0;
    if (m_pub && old_v && !bus.out_ready_i) e_ovr = 1'b1;
    else if (bus.clr_overrun_i) e_ovr = 1'b0;
    e_busy = (m_scan > 0);
  endtask

  task automatic compare_all();
    check_eq("out_valid", bus.out_valid_o, e_valid);
    check_eq("out_sum", bus.out_sum_o, e_sum);
    check_eq("out_min", bus.out_min_o, e_min);
    check_eq("out_max", bus.out_max_o, e_max);
    check_eq("out_max_idx", bus.out_max_idx_o, e_idx);
    check_eq("out_cnt", bus.out_cnt_o, e_cnt);
    check_eq("out_seq", bus.out_seq_o, e_seq);
    check_eq("overrun", bus.overrun_o, e_ovr);
    check_eq("busy", bus.busy_o, e_busy);
    check_eq("alarm_mask", bus.alarm_mask_o, e_mask);
    check_eq("alarm", bus.alarm_o, e_alarm);
  endtask

  // One clock: inputs already applied at the preceding negedge, sample outputs at the next negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Edges until the DUT's sequence number moves (bounded).
  task automatic measure(output int lat);
    logic [SEQ_W-1:0] seq0;
    seq0 = bus.out_seq_o;
    lat = 0;
    do begin step(); lat++; end while (bus.out_seq_o == seq0 && lat < 200);
  endtask

  task automatic set_ch(input logic [15:0] d0, d1, d2, d3, input logic [3:0] v);
    bus.ch_data_i  = {d3, d2, d1, d0};
    bus.ch_valid_i = v;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    if ($urandom_range(0, 2) == 0) return DATA_W'($urandom_range(0, 3));
    return DATA_W'($urandom);
  endfunction

  initial begin
    int lat;
    logic [SEQ_W-1:0] seq_save;
    rst_n = 1'b0;
    bus.enable_i = 1'b0; bus.sample_period_i = '0; bus.ch_data_i = '0; bus.ch_valid_i = '0;
    bus.alarm_thresh_i = '0; bus.out_ready_i = 1'b0; bus.clr_overrun_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Basic frame, latency P+NUM_CH.
    bus.sample_period_i = 8'd3; bus.alarm_thresh_i = 16'd39; bus.out_ready_i = 1'b1;
    set_ch(16'd10, 16'd40, 16'd40, 16'd5, 4'hF);
    bus.enable_i = 1'b1;
    step();
    measure(lat);
    check_eq("lat_first", lat, 7);
    check_eq("s1_sum", bus.out_sum_o, 95);
    check_eq("s1_min", bus.out_min_o, 5);
    check_eq("s1_max", bus.out_max_o, 40);
    check_eq("s1_idx", bus.out_max_idx_o, 1);
    check_eq("s1_cnt", bus.out_cnt_o, 4);
    check_eq("s1_seq", bus.out_seq_o, 1);
    check_eq("s1_mask", bus.alarm_mask_o, ALARM_ON ? 4'b0110 : 4'b0000);
    check_eq("s1_alarm", bus.alarm_o, ALARM_ON);
    // Change data after snapshot of frame 2: snapshot isolation is checked by the model.

    // Valid masking.
    set_ch(16'd10, 16'd40, 16'd40, 16'd5, 4'b0000);
    measure(lat);
    check_eq("lat_steady", lat, 7);
    check_eq("m0_sum", bus.out_sum_o, 0);
    check_eq("m0_min", bus.out_min_o, 16'hFFFF);
    check_eq("m0_max", bus.out_max_o, 0);
    check_eq("m0_cnt", bus.out_cnt_o, 0);
    set_ch(16'd7, 16'd99, 16'd3, 16'd99, 4'b0101);
    measure(lat);
    check_eq("m5_sum", bus.out_sum_o, 10);
    check_eq("m5_max", bus.out_max_o, 7);
    check_eq("m5_idx", bus.out_max_idx_o, 0);
    check_eq("m5_cnt", bus.out_cnt_o, 2);
    check_eq("m5_min", bus.out_min_o, 3);

    // Overrun on unread frame, clear, and publish coincident with ready.
    step();
    bus.out_ready_i = 1'b0;
    seq_save = e_seq;
    measure(lat);
    check_eq("ovr_first", bus.overrun_o, 0);
    measure(lat);
    check_eq("ovr_set", bus.overrun_o, 1);
    check_eq("ovr_seq", bus.out_seq_o, seq_save + 2'd2);
    bus.clr_overrun_i = 1'b1;
    step();
    bus.clr_overrun_i = 1'b0;
    check_eq("ovr_clr", bus.overrun_o, 0);
    for (int i = 0; i < 50 && m_scan != 1; i++) step();
    check_eq("sync_pub", m_scan, 1);
    bus.out_ready_i = 1'b1;
    step();
    check_eq("ovr_coinc", bus.overrun_o, 0);
    check_eq("coinc_valid", bus.out_valid_o, 1);

    // Abort mid-scan at channel 2, then full latency after re-enable.
    for (int i = 0; i < 50 && m_scan != NUM_CH - 2; i++) step();
    seq_save = e_seq;
    bus.enable_i = 1'b0;
    repeat (6) step();
    check_eq("abort_seq", bus.out_seq_o, seq_save);
    check_eq("abort_busy", bus.busy_o, 0);
    bus.enable_i = 1'b1;
    step();
    measure(lat);
    check_eq("lat_reenable", lat, 7);

    // Zero period and sequence wrap after 2^SEQ_W+1 frames from reset.
    rst_n = 1'b0;
    bus.enable_i = 1'b0;
    bus.sample_period_i = 8'd0;
    @(negedge clk);
    model_reset();
    compare_all();
    rst_n = 1'b1;
    bus.enable_i = 1'b1;
    step();
    measure(lat);
    check_eq("lat_p0", lat, 5);
    for (int f = 1; f < (1 << SEQ_W) + 1; f++) begin
      measure(lat);
      check_eq("period_p0", lat, 5);
    end
    check_eq("seq_wrap", bus.out_seq_o, 1);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      bus.enable_i        = ($urandom_range(0, 99) >= 3);
      bus.sample_period_i = PERIOD_W'($urandom_range(0, 4));
      bus.ch_data_i       = {rnd_data(), rnd_data(), rnd_data(), rnd_data()};
      bus.ch_valid_i      = NUM_CH'($urandom);
      bus.alarm_thresh_i  = rnd_data();
      bus.out_ready_i     = $urandom_range(0, 1) == 1;
      bus.clr_overrun_i   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
